token_buffer: RTL and testbench

- On-chip activation token store, 256 entries x 1024 bits.
- Sits directly upstream of the activation dispatcher. Loader/DMA writes tokens through a valid/ready port; the dispatcher reads them through a registered 1-cycle-latency port (rd_en/rd_addr in, rd_data/rd_valid out).
- Keeps a per-entry valid bitmap, so reads of not-yet-written entries return no data. The dispatcher keeps re-issuing the read until data is present.

---
 rtl/token_buffer_if.sv | 27 ++
 rtl/token_buffer.sv | 81 ++++++++
 tb/tb_token_buffer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/token_buffer_if.sv
// Loader write port, dispatcher read port and bitmap control for token_buffer.
interface token_buffer_if #(
  parameter int AW = 8,
  parameter int DW = 1024
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_miss;
  logic          clr;
  logic [AW:0]   fill_count;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_en, rd_addr, clr,
    input  wr_ready, rd_data, rd_valid, rd_miss, fill_count
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_en, rd_addr, clr,
    output wr_ready, rd_data, rd_valid, rd_miss, fill_count
  );
endinterface

// File: rtl/token_buffer.sv
// Activation token store with per-entry valid bitmap and 1-cycle registered read.
// Optional TBUF_CONSUME_EN: read hits invalidate the entry (one-shot tokens).
module token_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 1024
) (
  input logic           clk,
  input logic           rst_n,
  token_buffer_if.slave bus
);
  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] valid, valid_nxt;
  logic [AW:0]      fill;
  logic [DW-1:0]    rd_data_q;
  logic             rd_valid_q, rd_miss_q;
  logic             rst_done;
  logic             wr_ready, wr_fire, bypass, rd_hit, inc, dec;

  // Holds wr_ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_done <= 1'b0;
    else        rst_done <= 1'b1;

`ifdef TBUF_CONSUME_EN
  assign wr_ready = rst_done & ~valid[bus.wr_addr] & ~bus.clr;
`else
  assign wr_ready = rst_done & ~bus.clr;
`endif

  assign wr_fire = bus.wr_valid & wr_ready;
  assign bypass  = wr_fire & (bus.wr_addr == bus.rd_addr);
  assign rd_hit  = bus.rd_en & ~bus.clr & (valid[bus.rd_addr] | bypass);
  assign inc     = wr_fire & ~valid[bus.wr_addr];
`ifdef TBUF_CONSUME_EN
  assign dec     = rd_hit;
`else
  assign dec     = 1'b0;
`endif

  // Set before consume so a bypassed collision leaves the entry invalid.
  always_comb begin
    valid_nxt = valid;
    if (wr_fire) valid_nxt[bus.wr_addr] = 1'b1;
`ifdef TBUF_CONSUME_EN
    if (rd_hit)  valid_nxt[bus.rd_addr] = 1'b0;
`endif
    if (bus.clr) valid_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      fill  <= '0;
    end else begin
      valid <= valid_nxt;
      if (bus.clr)           fill <= '0;
      else if (inc && !dec)  fill <= fill + (AW+1)'(1);
      else if (dec && !inc)  fill <= fill - (AW+1)'(1);
    end

  always_ff @(posedge clk)
    if (wr_fire) mem[bus.wr_addr] <= bus.wr_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_miss_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_hit;
      rd_miss_q  <= bus.rd_en & ~rd_hit;
      if (rd_hit) rd_data_q <= bypass ? bus.wr_data : mem[bus.rd_addr];
    end

  assign bus.wr_ready   = wr_ready;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_miss    = rd_miss_q;
  assign bus.fill_count = fill;
endmodule

// File: tb/tb_token_buffer.sv
// Directed bench for token_buffer: reset, hit/miss, collision, full fill, clr, async reset.
module tb_token_buffer;
  localparam int AW = 8;
  localparam int DW = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  token_buffer_if #(.AW(AW), .DW(DW)) bus ();
  token_buffer #(.DEPTH(256), .AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int exp_fill = 0;

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {128{b}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = '0;
    bus.rd_en = 0; bus.rd_addr = 0; bus.clr = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b want=0", bus.rd_valid); end
    checks++; if (bus.rd_miss !== 1'b0) begin failures++; $display("FAIL reset_rd_miss got=%0b want=0", bus.rd_miss); end
    checks++; if (bus.rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%0h want=0", bus.rd_data[63:0]); end
    checks++; if (bus.fill_count !== 9'd0) begin failures++; $display("FAIL reset_fill got=%0d want=0", bus.fill_count); end
    rst_n = 1;
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL deassert_wr_ready got=%0b want=0", bus.wr_ready); end
    tick;
    checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL idle_wr_ready got=%0b want=1", bus.wr_ready); end
    bus.rd_en = 1; bus.rd_addr = 8'h05;
    tick;
    bus.rd_en = 0;
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL empty_rd_valid got=%0b want=0", bus.rd_valid); end
    checks++; if (bus.rd_miss !== 1'b1) begin failures++; $display("FAIL empty_rd_miss got=%0b want=1", bus.rd_miss); end
    checks++; if (bus.rd_data !== '0) begin failures++; $display("FAIL empty_rd_data got=%0h want=0", bus.rd_data[63:0]); end
    checks++; if (bus.fill_count !== 9'd0) begin failures++; $display("FAIL empty_fill got=%0d want=0", bus.fill_count); end
    tick;
    checks++; if (bus.rd_miss !== 1'b0) begin failures++; $display("FAIL miss_pulse got=%0b want=0", bus.rd_miss); end
  endtask

  task automatic test_write_read;
    bus.wr_valid = 1; bus.wr_addr = 8'h05; bus.wr_data = rep(8'hA5);
    tick;
    bus.wr_valid = 0;
    exp_fill = 1;
    bus.rd_en = 1; bus.rd_addr = 8'h05;
    tick;
    bus.rd_en = 0;
`ifdef TBUF_CONSUME_EN
    exp_fill = 0;
`endif
    checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL hit_rd_valid got=%0b want=1", bus.rd_valid); end
    checks++; if (bus.rd_data !== rep(8'hA5)) begin failures++; $display("FAIL hit_rd_data got=%0h want=a5..", bus.rd_data[63:0]); end
    checks++; if (bus.rd_miss !== 1'b0) begin failures++; $display("FAIL hit_rd_miss got=%0b want=0", bus.rd_miss); end
    checks++; if (bus.fill_count !== exp_fill[8:0]) begin failures++; $display("FAIL hit_fill got=%0d want=%0d", bus.fill_count, exp_fill); end
  endtask

  task automatic test_collision;
    bus.wr_valid = 1; bus.wr_addr = 8'h10; bus.wr_data = rep(8'h3C);
    bus.rd_en = 1; bus.rd_addr = 8'h10;
    #1;
    checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL coll_wr_ready got=%0b want=1", bus.wr_ready); end
    tick;
    bus.wr_valid = 0; bus.rd_en = 0;
`ifndef TBUF_CONSUME_EN
    exp_fill++;
`endif
    checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL coll_rd_valid got=%0b want=1", bus.rd_valid); end
    checks++; if (bus.rd_data !== rep(8'h3C)) begin failures++; $display("FAIL coll_rd_data got=%0h want=3c..", bus.rd_data[63:0]); end
    checks++; if (bus.rd_miss !== 1'b0) begin failures++; $display("FAIL coll_rd_miss got=%0b want=0", bus.rd_miss); end
    checks++; if (bus.fill_count !== exp_fill[8:0]) begin failures++; $display("FAIL coll_fill got=%0d want=%0d", bus.fill_count, exp_fill); end
`ifdef TBUF_CONSUME_EN
    bus.rd_en = 1;
    tick;
    bus.rd_en = 0;
    checks++; if (bus.rd_miss !== 1'b1) begin failures++; $display("FAIL coll_consumed got=%0b want=1", bus.rd_miss); end
`endif
  endtask

  task automatic test_fill;
    for (int a = 0; a < 256; a++) begin
      bus.wr_valid = 1; bus.wr_addr = a[7:0]; bus.wr_data = rep(a[7:0]);
      tick;
    end
    bus.wr_valid = 0;
    checks++; if (bus.fill_count !== 9'd256) begin failures++; $display("FAIL full_fill got=%0d want=256", bus.fill_count); end
    bus.wr_valid = 1; bus.wr_addr = 8'h00; bus.wr_data = rep(8'h00);
    #1;
`ifdef TBUF_CONSUME_EN
    checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL full_backpressure got=%0b want=0", bus.wr_ready); end
    bus.wr_valid = 0;
`else
    checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL overwrite_wr_ready got=%0b want=1", bus.wr_ready); end
    tick;
    bus.wr_valid = 0;
    checks++; if (bus.fill_count !== 9'd256) begin failures++; $display("FAIL overwrite_fill got=%0d want=256", bus.fill_count); end
`endif
    bus.rd_en = 1;
    for (int a = 0; a < 256; a++) begin
      bus.rd_addr = a[7:0];
      tick;
      checks++;
      if ({bus.rd_valid, bus.rd_data} !== {1'b1, rep(a[7:0])}) begin
        failures++;
        $display("FAIL sweep_read addr=%0d valid=%0b got=%0h want=%0h", a, bus.rd_valid, bus.rd_data[63:0], rep(a[7:0]) & 64'hffffffffffffffff);
      end
    end
    bus.rd_en = 0;
`ifdef TBUF_CONSUME_EN
    exp_fill = 0;
`else
    exp_fill = 256;
`endif
    checks++; if (bus.fill_count !== exp_fill[8:0]) begin failures++; $display("FAIL sweep_fill got=%0d want=%0d", bus.fill_count, exp_fill); end
  endtask

  task automatic test_clr;
    bus.clr = 1;
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL clr_wr_ready got=%0b want=0", bus.wr_ready); end
    tick;
    bus.clr = 0;
    checks++; if (bus.fill_count !== 9'd0) begin failures++; $display("FAIL clr_fill got=%0d want=0", bus.fill_count); end
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1; bus.wr_addr = i[7:0]; bus.wr_data = rep(8'h40 + i[7:0]);
      tick;
    end
    bus.wr_valid = 0;
    checks++; if (bus.fill_count !== 9'd4) begin failures++; $display("FAIL four_fill got=%0d want=4", bus.fill_count); end
    bus.rd_en = 1; bus.rd_addr = 8'h02;
    tick;
    bus.clr = 1; bus.rd_addr = 8'h00;
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL clr2_wr_ready got=%0b want=0", bus.wr_ready); end
    tick;
    bus.clr = 0; bus.rd_en = 0;
    checks++; if (bus.fill_count !== 9'd0) begin failures++; $display("FAIL clr2_fill got=%0d want=0", bus.fill_count); end
    checks++; if (bus.rd_miss !== 1'b1) begin failures++; $display("FAIL clr_rd_miss got=%0b want=1", bus.rd_miss); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL clr_rd_valid got=%0b want=0", bus.rd_valid); end
    checks++; if (bus.rd_data !== rep(8'h42)) begin failures++; $display("FAIL clr_rd_hold got=%0h want=42..", bus.rd_data[63:0]); end
  endtask

  task automatic test_reset_mid;
    bus.wr_valid = 1; bus.wr_addr = 8'h07; bus.wr_data = rep(8'h77);
    tick;
    bus.wr_valid = 0;
    bus.rd_en = 1; bus.rd_addr = 8'h07;
    #2;
    rst_n = 0;
    #1;
    checks++; if (bus.fill_count !== 9'd0) begin failures++; $display("FAIL async_fill got=%0d want=0", bus.fill_count); end
    @(posedge clk);
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL async_rd_valid got=%0b want=0", bus.rd_valid); end
    bus.rd_en = 0;
    rst_n = 1;
    tick;
    bus.rd_en = 1;
    tick;
    bus.rd_en = 0;
    checks++; if (bus.rd_miss !== 1'b1) begin failures++; $display("FAIL async_cleared got=%0b want=1", bus.rd_miss); end
    checks++; if (bus.rd_data !== '0) begin failures++; $display("FAIL async_rd_data got=%0h want=0", bus.rd_data[63:0]); end
  endtask

`ifdef TBUF_CONSUME_EN
  task automatic test_consume;
    bus.wr_valid = 1; bus.wr_addr = 8'h20; bus.wr_data = rep(8'h20);
    tick;
    bus.wr_valid = 0;
    checks++; if (bus.fill_count !== 9'd1) begin failures++; $display("FAIL cons_fill1 got=%0d want=1", bus.fill_count); end
    bus.wr_valid = 1; bus.wr_data = rep(8'h21);
    bus.rd_en = 1; bus.rd_addr = 8'h20;
    #1;
    checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL cons_backpressure got=%0b want=0", bus.wr_ready); end
    tick;
    bus.rd_en = 0;
    checks++; if (bus.rd_data !== rep(8'h20)) begin failures++; $display("FAIL cons_rd_data got=%0h want=20..", bus.rd_data[63:0]); end
    checks++; if (bus.fill_count !== 9'd0) begin failures++; $display("FAIL cons_fill0 got=%0d want=0", bus.fill_count); end
    checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL cons_release got=%0b want=1", bus.wr_ready); end
    tick;
    bus.wr_valid = 0;
    checks++; if (bus.fill_count !== 9'd1) begin failures++; $display("FAIL cons_refill got=%0d want=1", bus.fill_count); end
    bus.rd_en = 1;
    tick;
    checks++; if (bus.rd_data !== rep(8'h21)) begin failures++; $display("FAIL cons_new_data got=%0h want=21..", bus.rd_data[63:0]); end
    tick;
    bus.rd_en = 0;
    checks++; if (bus.rd_miss !== 1'b1) begin failures++; $display("FAIL cons_repeat_miss got=%0b want=1", bus.rd_miss); end
  endtask
`endif

  initial begin
    test_reset;
    test_write_read;
    test_collision;
    test_fill;
    test_clr;
    test_reset_mid;
`ifdef TBUF_CONSUME_EN
    test_consume;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
